// File: rtl/gb_timer.sv
// DMG timer block: DIV/TIMA/TMA/TAC on a 100 MHz clk with cpu_clk tick detect.
// Define GB_TIMER_RELOAD_DELAY_EN for the 4-tick delayed TIMA reload.
module gb_timer #(
  parameter int SYS_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_clk,
  input  logic [1:0] reg_sel,
  input  logic       wr_en,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       tick,
  output logic       irq_timer
);

  logic             cpu_clk_q;
  logic             tick_q;
  logic             irq_q, irq_d;
  logic [SYS_W-1:0] sys_q, sys_d;
  logic [7:0]       tima_q, tima_d;
  logic [7:0]       tma_q, tma_d;
  logic [2:0]       tac_q, tac_d;
  logic             tick_c;
  logic             we_div, we_tima, we_tma, we_tac;
  logic             sig_cur, sig_nxt, fall_c;

`ifdef GB_TIMER_RELOAD_DELAY_EN
  logic [2:0]       rld_q, rld_d;
  logic             rld_ev;
`endif

  function automatic logic timer_sig(
    input logic [2:0]       tac,
    input logic [SYS_W-1:0] cnt
  );
    logic b;
    unique case (tac[1:0])
      2'b00: b = cnt[9];
      2'b01: b = cnt[3];
      2'b10: b = cnt[5];
      2'b11: b = cnt[7];
    endcase
    return tac[2] & b;
  endfunction

  assign tick_c  = cpu_clk & ~cpu_clk_q;
  assign we_div  = wr_en && (reg_sel == 2'd0);
  assign we_tima = wr_en && (reg_sel == 2'd1);
  assign we_tma  = wr_en && (reg_sel == 2'd2);
  assign we_tac  = wr_en && (reg_sel == 2'd3);

  // system counter, TMA and TAC next state; a DIV write beats the tick
  always_comb begin
    sys_d = sys_q;
    if (we_div)
      sys_d = '0;
    else if (tick_c)
      sys_d = sys_q + {{(SYS_W-1){1'b0}}, 1'b1};
    tma_d = we_tma ? wdata : tma_q;
    tac_d = we_tac ? wdata[2:0] : tac_q;
  end

  // falling edge of the gated source bit, across old and new state
  always_comb begin
    sig_cur = timer_sig(tac_q, sys_q);
    sig_nxt = timer_sig(tac_d, sys_d);
    fall_c  = sig_cur & ~sig_nxt;
  end

`ifdef GB_TIMER_RELOAD_DELAY_EN
  // TIMA next state with 4-tick reload window and write cancel
  always_comb begin
    tima_d = tima_q;
    irq_d  = 1'b0;
    rld_d  = rld_q;
    rld_ev = (rld_q == 3'd1) && tick_c;
    if (rld_ev) begin
      tima_d = tma_d;
      irq_d  = 1'b1;
      rld_d  = 3'd0;
    end else if (we_tima) begin
      tima_d = wdata;
      rld_d  = 3'd0;
    end else if (rld_q != 3'd0) begin
      if (tick_c)
        rld_d = rld_q - 3'd1;
    end else if (fall_c) begin
      if (tima_q == 8'hFF) begin
        tima_d = 8'h00;
        rld_d  = 3'd4;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
  end
`else
  // TIMA next state with immediate reload on overflow
  always_comb begin
    tima_d = tima_q;
    irq_d  = 1'b0;
    if (we_tima) begin
      tima_d = wdata;
    end else if (fall_c) begin
      if (tima_q == 8'hFF) begin
        tima_d = tma_d;
        irq_d  = 1'b1;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
  end
`endif

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      irq_q     <= 1'b0;
      sys_q     <= '0;
      tima_q    <= 8'h00;
      tma_q     <= 8'h00;
      tac_q     <= 3'd0;
    end else begin
      cpu_clk_q <= cpu_clk;
      tick_q    <= tick_c;
      irq_q     <= irq_d;
      sys_q     <= sys_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
    end
  end

`ifdef GB_TIMER_RELOAD_DELAY_EN
  // reload window tick counter
  always_ff @(posedge clk) begin
    if (!rst_n)
      rld_q <= 3'd0;
    else
      rld_q <= rld_d;
  end
`endif

  // combinational register read
  always_comb begin
    rdata = 8'h00;
    unique case (reg_sel)
      2'd0: rdata = sys_q[SYS_W-1 -: 8];
      2'd1: rdata = tima_q;
      2'd2: rdata = tma_q;
      2'd3: rdata = {5'b11111, tac_q};
    endcase
  end

  assign tick      = tick_q;
  assign irq_timer = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
// Scoreboard bench for gb_timer: directed stimulus, queued expectations,
// negedge monitor comparing reads, levels and pulse counts.
module tb_gb_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_clk = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic       wr_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       tick;
  logic       irq_timer;

  gb_timer #(.SYS_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_clk   (cpu_clk),
    .reg_sel   (reg_sel),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rdata     (rdata),
    .tick      (tick),
    .irq_timer (irq_timer)
  );

  always #5 clk = ~clk;

  localparam int K_RD   = 0;
  localparam int K_TICK = 1;
  localparam int K_IRQ  = 2;
  localparam int K_IRQN = 3;
  localparam int K_TCKN = 4;

  typedef struct {
    string       nm;
    int          kind;
    logic [1:0]  sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  logic chk = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  int   tick_cnt = 0;
  int   irq_cnt = 0;
  int   exp_ticks = 0;
  int   exp_irq = 0;

`ifdef GB_TIMER_RELOAD_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  // monitor: count pulses, pop and compare on each check strobe
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (tick === 1'b1) tick_cnt++;
    if (irq_timer === 1'b1) irq_cnt++;
    if (chk) begin
      n_run++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: no expected entry queued");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          K_RD:    act = {24'd0, rdata};
          K_TICK:  act = {31'd0, tick};
          K_IRQ:   act = {31'd0, irq_timer};
          K_IRQN:  act = irq_cnt;
          default: act = tick_cnt;
        endcase
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, act, e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_clk = 1'b1;
      step();
      cpu_clk = 1'b0;
      step();
      exp_ticks++;
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] d);
    reg_sel = s;
    wdata   = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic check(input string nm, input int kind,
                       input logic [1:0] s, input logic [31:0] e);
    exp_t x;
    x.nm   = nm;
    x.kind = kind;
    x.sel  = s;
    x.exp  = e;
    reg_sel = s;
    sb.push_back(x);
    chk = 1'b1;
    step();
    chk = 1'b0;
  endtask

  initial begin
    // reset with cpu_clk toggling
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_clk = ~cpu_clk;
      step();
    end
    cpu_clk = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rst_div", K_RD, 2'd0, 32'h00);
    check("rst_tima", K_RD, 2'd1, 32'h00);
    check("rst_tma", K_RD, 2'd2, 32'h00);
    check("rst_tac", K_RD, 2'd3, 32'hF8);
    check("rst_tick", K_TICK, 2'd0, 32'd0);
    check("rst_irq", K_IRQ, 2'd0, 32'd0);

    // DIV counts 256 ticks per step, write clears
    do_tick(256);
    check("div_256", K_RD, 2'd0, 32'h01);
    check("tima_idle", K_RD, 2'd1, 32'h00);
    check("tick_cnt_256", K_TCKN, 2'd0, exp_ticks);
    wr(2'd0, 8'hAB);
    check("div_clr", K_RD, 2'd0, 32'h00);

    // TIMA on bit3: +1 every 16 ticks, overflow into TMA
    wr(2'd3, 8'h05);
    check("tac_rd", K_RD, 2'd3, 32'hFD);
    wr(2'd2, 8'hF0);
    wr(2'd1, 8'hFE);
    check("tima_wr", K_RD, 2'd1, 32'hFE);
    do_tick(16);
    check("tima_ff", K_RD, 2'd1, 32'hFF);
    do_tick(16);
    if (!DLY) exp_irq++;
    check("tima_ovf", K_RD, 2'd1, DLY ? 32'h00 : 32'hF0);
    do_tick(3);
    check("tima_win3", K_RD, 2'd1, DLY ? 32'h00 : 32'hF0);
    check("irq_win3", K_IRQN, 2'd0, exp_irq);
    do_tick(1);
    if (DLY) exp_irq++;
    check("tima_rld", K_RD, 2'd1, 32'hF0);
    check("irq_rld", K_IRQN, 2'd0, exp_irq);

    // TIMA write two ticks into the window cancels the reload
    wr(2'd0, 8'h00);
    wr(2'd1, 8'hFE);
    do_tick(32);
    if (!DLY) exp_irq++;
    do_tick(2);
    wr(2'd1, 8'h42);
    check("cancel_val", K_RD, 2'd1, 32'h42);
    do_tick(4);
    check("cancel_hold", K_RD, 2'd1, 32'h42);
    check("cancel_irq", K_IRQN, 2'd0, exp_irq);

    // DIV write with source bit high gives one increment
    wr(2'd0, 8'h00);
    do_tick(8);
    check("pre_divglitch", K_RD, 2'd1, 32'h42);
    wr(2'd0, 8'h55);
    check("div_glitch", K_RD, 2'd1, 32'h43);

    // timer disabled: TIMA frozen for 1000 ticks
    wr(2'd1, 8'h10);
    wr(2'd3, 8'h00);
    do_tick(1000);
    check("tac_off", K_RD, 2'd1, 32'h10);
    check("div_1000", K_RD, 2'd0, 32'h03);

    // overflow from a DIV write, then reset inside the window
    wr(2'd3, 8'h05);
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h00);
    if (!DLY) exp_irq++;
    check("wr_ovf", K_RD, 2'd1, DLY ? 32'h00 : 32'hF0);
    check("wr_ovf_irq", K_IRQN, 2'd0, exp_irq);
    do_tick(2);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("mrst_tima", K_RD, 2'd1, 32'h00);
    check("mrst_tac", K_RD, 2'd3, 32'hF8);
    do_tick(8);
    check("mrst_tima2", K_RD, 2'd1, 32'h00);
    check("mrst_irq", K_IRQN, 2'd0, exp_irq);
    check("tick_total", K_TCKN, 2'd0, exp_ticks);

    step();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_left: %0d entries remain, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
